// File: rtl/ram_load_arbiter_if.sv
// ram_load_arbiter_if: groups the loader stream, CPU hold/restart and RAM-bus
// signals that connect ram_load_arbiter to the loader and to control_module.
// The slave modport is the arbiter's view; the master modport is the
// surrounding system (loader, control_module, bus).
interface ram_load_arbiter_if #(
  parameter int DATA_W = 8
);
  // Loader byte stream
  logic              load_req;
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              byte_last;
  logic              byte_ready;
  // CPU coordination
  logic              cpu_boundary;
  logic              cpu_hold;
  logic              cpu_rst_o;
  logic              load_gnt;
  // Shared bus and RAM strobes
  logic [DATA_W-1:0] bus_o;
  logic              bus_oe;
  logic              mai_o;
  logic              mi_o;
  logic              mo_o;
  logic [DATA_W-1:0] bus_i;
  // Status
  logic              done;
  logic              overflow;
  logic              verify_err;

  modport slave (
    input  load_req, byte_valid, byte_data, byte_last, cpu_boundary, bus_i,
    output byte_ready, cpu_hold, cpu_rst_o, load_gnt, bus_o, bus_oe,
           mai_o, mi_o, mo_o, done, overflow, verify_err
  );

  modport master (
    output load_req, byte_valid, byte_data, byte_last, cpu_boundary, bus_i,
    input  byte_ready, cpu_hold, cpu_rst_o, load_gnt, bus_o, bus_oe,
           mai_o, mi_o, mo_o, done, overflow, verify_err
  );
endinterface

// File: rtl/ram_load_arbiter.sv
// ram_load_arbiter: lets an external program loader take the CPU bus between
// instructions, write a byte stream into RAM through the MAR/RAM strobes and
// restart the CPU afterwards.
// Optional feature macro: READBACK_VERIFY_EN adds a CHECK state that reads each
// written byte back over the bus and flags mismatches in verify_err.
module ram_load_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 16
) (
  input logic               clk,
  input logic               rst,
  ram_load_arbiter_if.slave lb
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_BND = 3'd1;
  localparam logic [2:0] S_GRANT    = 3'd2;
  localparam logic [2:0] S_WR_ADDR  = 3'd3;
  localparam logic [2:0] S_WR_DATA  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
`ifdef READBACK_VERIFY_EN
  localparam logic [2:0] S_CHECK    = 3'd6;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              last_q, last_d;
  logic              overflow_q, overflow_d;
  logic              write_end;
`ifdef READBACK_VERIFY_EN
  logic              verify_err_q, verify_err_d;
`endif

  // The state that finishes one byte and decides what comes next.
`ifdef READBACK_VERIFY_EN
  assign write_end = (state_q == S_CHECK);
`else
  assign write_end = (state_q == S_WR_DATA);
`endif

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    byte_d     = byte_q;
    last_d     = last_q;
    overflow_d = overflow_q;
`ifdef READBACK_VERIFY_EN
    verify_err_d = verify_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (lb.load_req) begin
          state_d    = S_WAIT_BND;
          addr_d     = '0;
          overflow_d = 1'b0;
`ifdef READBACK_VERIFY_EN
          verify_err_d = 1'b0;
`endif
        end
      end
      S_WAIT_BND: begin
        if (!lb.load_req)         state_d = S_IDLE;
        else if (lb.cpu_boundary) state_d = S_GRANT;
      end
      S_GRANT: begin
        // A byte offered in the same cycle load_req drops is still taken;
        // the abort then happens on the return to GRANT.
        if (lb.byte_valid) begin
          byte_d  = lb.byte_data;
          last_d  = lb.byte_last;
          state_d = S_WR_ADDR;
        end else if (!lb.load_req) begin
          state_d = S_IDLE;
        end
      end
      S_WR_ADDR: state_d = S_WR_DATA;
`ifdef READBACK_VERIFY_EN
      S_WR_DATA: state_d = S_CHECK;
      S_CHECK: begin
        if (lb.bus_i != byte_q) verify_err_d = 1'b1;
      end
`endif
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // End of a byte: finish on the last byte or when RAM is full, else move on.
    if (write_end) begin
      if (last_q) begin
        state_d = S_DONE;
      end else if (addr_q == LAST_ADDR) begin
        overflow_d = 1'b1;
        state_d    = S_DONE;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = S_GRANT;
      end
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef READBACK_VERIFY_EN
      verify_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge value regardless of statement order.
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
`ifdef READBACK_VERIFY_EN
      verify_err_q <= verify_err_d;
`endif
    end
  end

  // Outputs decode from state alone, so reset clears them immediately.
  always_comb begin
    lb.cpu_hold   = (state_q != S_IDLE);
    lb.byte_ready = (state_q == S_GRANT);
    lb.load_gnt   = (state_q == S_GRANT) || (state_q == S_WR_ADDR) ||
                    (state_q == S_WR_DATA);
    lb.bus_oe     = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA);
    lb.mai_o      = (state_q == S_WR_ADDR);
    lb.mi_o       = (state_q == S_WR_DATA);
    lb.mo_o       = 1'b0;
    lb.done       = (state_q == S_DONE);
    lb.cpu_rst_o  = (state_q == S_DONE);
    lb.bus_o      = '0;
    if (state_q == S_WR_ADDR) lb.bus_o = DATA_W'(addr_q);
    if (state_q == S_WR_DATA) lb.bus_o = byte_q;
`ifdef READBACK_VERIFY_EN
    if (state_q == S_CHECK) begin
      lb.load_gnt = 1'b1;
      lb.mo_o     = 1'b1;
    end
`endif
  end

  assign lb.overflow = overflow_q;
`ifdef READBACK_VERIFY_EN
  assign lb.verify_err = verify_err_q;
`else
  assign lb.verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_load_arbiter.sv
// tb_ram_load_arbiter: directed bench for ram_load_arbiter with a MAR/RAM
// model driven by the arbiter's strobes. Works with or without
// READBACK_VERIFY_EN defined.
module tb_ram_load_arbiter;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 16;
`ifdef READBACK_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_load_arbiter_if #(.DATA_W(DATA_W)) ifc ();

  ram_load_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lb (ifc)
  );

  // MAR + RAM model clocked by the arbiter's strobes
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ram [MEM_DEPTH];
  logic              force_ff;

  always @(posedge clk) begin
    if (ifc.mai_o) mar <= ifc.bus_o[ADDR_W-1:0];
    if (ifc.mi_o)  ram[mar] <= ifc.bus_o;
  end

  assign ifc.bus_i = !ifc.mo_o ? '0 : (force_ff ? 8'hFF : ram[mar]);

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int crst_cnt = 0;
  int viol     = 0;

  // Pulse counters and protocol invariants sampled mid-cycle
  always @(negedge clk) begin
    if (ifc.done)      done_cnt++;
    if (ifc.cpu_rst_o) crst_cnt++;
    if ((ifc.mai_o || ifc.mi_o || ifc.mo_o) && !ifc.cpu_hold) viol++;
    if (int'(ifc.mai_o) + int'(ifc.mi_o) + int'(ifc.mo_o) > 1) viol++;
    if (ifc.bus_oe && !(ifc.mai_o || ifc.mi_o)) viol++;
    if (ifc.done != ifc.cpu_rst_o) viol++;
    if (!VERIFY && (ifc.mo_o || ifc.verify_err)) viol++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // {hold, gnt, ready, oe, mai, mi, mo, done, cpu_rst, bus_o}
  function automatic logic [16:0] outs();
    return {ifc.cpu_hold, ifc.load_gnt, ifc.byte_ready, ifc.bus_oe, ifc.mai_o,
            ifc.mi_o, ifc.mo_o, ifc.done, ifc.cpu_rst_o, ifc.bus_o};
  endfunction

  localparam logic [8:0] F_IDLE  = 9'b000000000;
  localparam logic [8:0] F_WAIT  = 9'b100000000;
  localparam logic [8:0] F_GRANT = 9'b111000000;
  localparam logic [8:0] F_WADDR = 9'b110110000;
  localparam logic [8:0] F_WDATA = 9'b110101000;
  localparam logic [8:0] F_CHECK = 9'b110000100;
  localparam logic [8:0] F_DONE  = 9'b100000011;

  typedef struct {
    logic        lreq;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        bnd;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic lreq, input logic valid, input logic [7:0] data,
                              input logic last, input logic bnd,
                              input logic [8:0] flags, input logic [7:0] bo);
    vec_t v;
    v.lreq = lreq; v.valid = valid; v.data = data; v.last = last; v.bnd = bnd;
    v.exp  = {flags, bo};
    return v;
  endfunction

  logic [7:0] src [32];

  task automatic idle_inputs();
    ifc.load_req = 1'b0; ifc.byte_valid = 1'b0; ifc.byte_data = '0;
    ifc.byte_last = 1'b0; ifc.cpu_boundary = 1'b0;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < MEM_DEPTH; i++) ram[i] = '0;
  endtask

  // Streams n bytes from src; called and returns #1 after a posedge.
  task automatic run_load(input int n, input bit with_last, input bit expect_done,
                          output int accepted);
    bit got, stop;
    accepted = 0;
    stop     = 1'b0;
    ifc.load_req     = 1'b1;
    ifc.cpu_boundary = 1'b1;
    for (int i = 0; i < n && !stop; i++) begin
      ifc.byte_valid = 1'b1;
      ifc.byte_data  = src[i];
      ifc.byte_last  = with_last && (i == n - 1);
      got = 1'b0;
      for (int c = 0; c < 20 && !got && !stop; c++) begin
        @(negedge clk);
        if (ifc.byte_ready) got = 1'b1;
        else if (ifc.done)  stop = 1'b1;
        @(posedge clk); #1;
      end
      ifc.byte_valid = 1'b0;
      ifc.byte_last  = 1'b0;
      if (got) accepted++;
      else if (!stop) check("byte_ready_timeout", 32'd0, 32'd1);
    end
    if (!expect_done) begin
      ifc.load_req = 1'b0;
      repeat (8) @(posedge clk);
      #1;
    end else begin
      for (int c = 0; c < 20 && !stop; c++) begin
        @(negedge clk);
        if (ifc.done) stop = 1'b1;
        @(posedge clk); #1;
      end
      if (!stop) check("done_timeout", 32'd0, 32'd1);
      ifc.load_req = 1'b0;
    end
    ifc.cpu_boundary = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, d0, r0;
    bit found;
    force_ff = 1'b0;
    mar = '0;
    clear_ram();
    idle_inputs();

    // Reset state, even with requests asserted
    #12;
    ifc.load_req = 1'b1; ifc.cpu_boundary = 1'b1;
    #10;
    check("reset_outputs", 32'(outs()), 32'd0);
    check("reset_status", {30'd0, ifc.overflow, ifc.verify_err}, 32'd0);
    idle_inputs();
    #3 rst = 1'b0;

    // Cycle-exact table: 5 cycles without boundary, then a single-byte load
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, F_IDLE, 8'h00));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 8'h00, 0, 0, F_WAIT, 8'h00));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, F_WAIT,  8'h00));
    vecs.push_back(mk(1, 1, 8'hA5, 1, 1, F_GRANT, 8'h00));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, F_WADDR, 8'h00));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, F_WDATA, 8'hA5));
    if (VERIFY) vecs.push_back(mk(1, 0, 8'h00, 0, 1, F_CHECK, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, F_DONE, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, F_IDLE, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, F_IDLE, 8'h00));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      ifc.load_req     = vecs[i].lreq;
      ifc.byte_valid   = vecs[i].valid;
      ifc.byte_data    = vecs[i].data;
      ifc.byte_last    = vecs[i].last;
      ifc.cpu_boundary = vecs[i].bnd;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    check("vec_ram0", 32'(ram[0]), 32'hA5);
    check("vec_no_verify_err", 32'(ifc.verify_err), 32'd0);
    @(posedge clk); #1;

    // Three-byte load
    clear_ram();
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
    d0 = done_cnt; r0 = crst_cnt;
    run_load(3, 1'b1, 1'b1, acc);
    check("load3_accepted", 32'(acc), 32'd3);
    check("load3_ram", {8'd0, ram[0], ram[1], ram[2]}, 32'h00112233);
    check("load3_done_cycles", 32'(done_cnt - d0), 32'd1);
    check("load3_cpu_rst_cycles", 32'(crst_cnt - r0), 32'd1);
    check("load3_overflow", 32'(ifc.overflow), 32'd0);
    check("load3_idle", 32'(outs()), 32'd0);

    // Overflow: 17 bytes, no last marker
    clear_ram();
    for (int i = 0; i < 17; i++) src[i] = 8'h40 + 8'(i);
    d0 = done_cnt;
    run_load(17, 1'b0, 1'b1, acc);
    check("ovf_accepted", 32'(acc), 32'd16);
    check("ovf_flag", 32'(ifc.overflow), 32'd1);
    check("ovf_ram_first_last", {16'd0, ram[0], ram[15]}, 32'h0000404F);
    check("ovf_done_cycles", 32'(done_cnt - d0), 32'd1);

    // Abort in GRANT after two bytes; overflow clears on the new request
    clear_ram();
    src[0] = 8'hA1; src[1] = 8'hA2;
    d0 = done_cnt; r0 = crst_cnt;
    run_load(2, 1'b0, 1'b0, acc);
    check("abort_accepted", 32'(acc), 32'd2);
    check("abort_ram", {8'd0, ram[0], ram[1], ram[2]}, 32'h00A1A200);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_cpu_rst", 32'(crst_cnt - r0), 32'd0);
    check("abort_released", 32'(outs()), 32'd0);
    check("abort_overflow_cleared", 32'(ifc.overflow), 32'd0);

    // Asynchronous reset while writing RAM
    ifc.load_req = 1'b1; ifc.cpu_boundary = 1'b1;
    ifc.byte_valid = 1'b1; ifc.byte_data = 8'h99; ifc.byte_last = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (ifc.byte_ready) begin
        @(posedge clk); #1;
        ifc.byte_valid = 1'b0;
      end else if (ifc.mi_o) begin
        found = 1'b1;
      end
    end
    check("rst_reached_wr_data", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", 32'(outs()), 32'd0);
    idle_inputs();
    @(negedge clk);
    #2 rst = 1'b0;
    clear_ram();
    src[0] = 8'h77;
    @(posedge clk); #1;
    run_load(1, 1'b1, 1'b1, acc);
    check("rst_restart_addr0", {16'd0, ram[0], ram[1]}, 32'h00007700);

    // Readback forced to 0xFF: flagged only when verification is built in
    clear_ram();
    src[0] = 8'h5A;
    force_ff = 1'b1;
    d0 = done_cnt;
    run_load(1, 1'b1, 1'b1, acc);
    force_ff = 1'b0;
    check("verify_err_flag", 32'(ifc.verify_err), 32'(VERIFY));
    check("verify_load_completes", 32'(done_cnt - d0), 32'd1);
    check("verify_ram", 32'(ram[0]), 32'h5A);
    src[0] = 8'h3C;
    run_load(1, 1'b1, 1'b1, acc);
    check("verify_err_cleared", 32'(ifc.verify_err), 32'd0);

    check("strobe_invariants", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
